// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around a single full-adder slice.
// An accepted start latches a, b and cin, then WIDTH RUN cycles process one
// bit per clock LSB-first. On the last RUN edge the result is loaded into the
// output registers at once and done pulses for one cycle.
//
// Parameters:
//   WIDTH   operand/result width in bits (1..32)
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   begin an addition (accepted in IDLE or DONE only)
//   a, b    operands, cin carry-in (sampled with an accepted start)
//   busy    high while the addition runs
//   done    one-cycle completion pulse
//   sum     (a+b+cin) mod 2^WIDTH, held until the next completion
//   cout    carry-out, held with sum
//   ovf     signed overflow, held with sum (only with SERIAL_ADDER_OVF_EN)
//
// Build option: define SERIAL_ADDER_OVF_EN to add the ovf output.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             bit_c;
    logic             carry_c;
    logic             last_c;

    // Single full-adder slice on the current LSBs
    assign bit_c   = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign carry_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    assign last_c  = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    c_d     = cin;
                    ps_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                c_d    = carry_c;
                // New bit enters at the MSB so after WIDTH shifts bit 0 is the LSB
                ps_d   = (ps_q >> 1) | (WIDTH'(bit_c) << (WIDTH - 1));
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_c) begin
                    sum_d   = ps_d;
                    cout_d  = carry_c;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            ps_q   <= '0;
            sum_q  <= '0;
            c_q    <= 1'b0;
            cout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            ps_q   <= ps_d;
            sum_q  <= sum_d;
            c_q    <= c_d;
            cout_q <= cout_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // Operand sign bits are shifted out during RUN, so keep copies for ovf
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if ((state_q != S_RUN) && start) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end else if ((state_q == S_RUN) && last_c) begin
            // The bit produced on the final RUN edge is the sum MSB
            ovf_d = (a_msb_q == b_msb_q) && (bit_c != a_msb_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 instance checked by a scoreboard fed
// from an arithmetic reference model, plus a WIDTH=1 truth-table instance.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) u_w1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int unsigned  at;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned edge_n;
    int unsigned free_edge;
    int unsigned acc_edge;
    bit          active;
    int          checks;
    int          failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference: plain integer addition, result due WIDTH edges after accept
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input int unsigned at);
        exp_t        e;
        logic [W:0]  t;
        t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        e.s  = t[W-1:0];
        e.c  = t[W];
        e.o  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        e.at = at;
        return e;
    endfunction

    // One clock: drive after the negedge, record acceptance at the posedge
    task automatic cycle(input logic st, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ci);
        #1;
        start = st;
        a     = ai;
        b     = bi;
        cin   = ci;
        @(posedge clk);
        edge_n++;
        if (st && !rst && edge_n >= free_edge) begin
            sb_q.push_back(model(ai, bi, ci, edge_n + W));
            acc_edge  = edge_n;
            active    = 1'b1;
            free_edge = edge_n + W + 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
    endtask

    task automatic rand_op();
        cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    // One-cycle reset with start held high; outputs must clear immediately
    task automatic pulse_reset();
        #1;
        rst   = 1'b1;
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        sb_q.delete();
        active = 1'b0;
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        #1;
        rst       = 1'b0;
        start     = 1'b0;
        free_edge = edge_n + 1;
    endtask

    // Monitor: timing model for busy/done, scoreboard for results
    initial begin : monitor
        logic [W-1:0] hold_s;
        logic         hold_c;
        logic         hold_o;
        bit           bexp;
        bit           dexp;
        exp_t         e;
        hold_s = '0;
        hold_c = 1'b0;
        hold_o = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_s = '0;
                hold_c = 1'b0;
                hold_o = 1'b0;
            end else begin
                bexp = active && (edge_n >= acc_edge) && (edge_n < acc_edge + W);
                dexp = active && (edge_n == acc_edge + W);
                chk("busy", 32'(busy), 32'(bexp));
                chk("done", 32'(done), 32'(dexp));
                chk("busy_done_excl", 32'(busy & done), 32'd0);
                if (done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_unexpected: got done=1 expected no result pending (edge %0d)",
                                 edge_n);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_edge", 32'(edge_n), 32'(e.at));
                        chk("sum", 32'(sum), 32'(e.s));
                        chk("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
                        chk("ovf", 32'(ovf), 32'(e.o));
`endif
                        hold_s = e.s;
                        hold_c = e.c;
                        hold_o = e.o;
                    end
                end else begin
                    chk("sum_hold", 32'(sum), 32'(hold_s));
                    chk("cout_hold", 32'(cout), 32'(hold_c));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf_hold", 32'(ovf), 32'(hold_o));
`endif
                end
            end
        end
    end

    // Stimulus
    initial begin : driver
        logic [1:0] t1;
        checks    = 0;
        failures  = 0;
        edge_n    = 0;
        free_edge = 0;
        acc_edge  = 0;
        active    = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        start1    = 1'b0;
        a1        = '0;
        b1        = '0;
        cin1      = 1'b0;
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_sum", 32'(sum), 32'd0);
        chk("init_cout", 32'(cout), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst       = 1'b0;
        free_edge = edge_n + 1;
        idle(2);

        // Basic cases
        cycle(1'b1, 8'h0F, 8'h01, 1'b0);
        idle(10);
        cycle(1'b1, 8'hFF, 8'h01, 1'b0);
        idle(9);
        cycle(1'b1, 8'h7F, 8'h01, 1'b0);
        idle(9);
        cycle(1'b1, 8'h80, 8'h80, 1'b1);
        idle(9);

        // Start during RUN is ignored
        cycle(1'b1, 8'h12, 8'h34, 1'b0);
        idle(2);
        cycle(1'b1, 8'hAA, 8'h55, 1'b0);
        idle(9);

        // Reset mid-RUN aborts, start held during reset is ignored
        cycle(1'b1, 8'hC3, 8'h5A, 1'b1);
        idle(3);
        pulse_reset();
        idle(12);

        // Back-to-back with start held high
        for (int i = 0; i < 45; i++) rand_op();
        idle(10);

        // Random traffic with gaps and starts during RUN
        for (int n = 0; n < 40; n++) begin
            idle($urandom_range(0, 3));
            rand_op();
            for (int j = 0; j < int'(W) + int'($urandom_range(0, 2)); j++) begin
                cycle(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom), 1'($urandom));
            end
        end
        idle(12);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // WIDTH=1 full-adder truth table, starts accepted in DONE
        for (int i = 0; i < 8; i++) begin
            a1     = 1'(i >> 2);
            b1     = 1'(i >> 1);
            cin1   = 1'(i);
            start1 = 1'b1;
            idle(1);
            start1 = 1'b0;
            chk("w1_busy", 32'(busy1), 32'd1);
            chk("w1_done_early", 32'(done1), 32'd0);
            idle(1);
            t1 = 2'(a1) + 2'(b1) + 2'(cin1);
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_busy_off", 32'(busy1), 32'd0);
            chk("w1_sum", 32'(sum1), 32'(t1[0]));
            chk("w1_cout", 32'(cout1), 32'(t1[1]));
        end
        idle(2);
        chk("w1_idle_done", 32'(done1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 SHALL have port: a  input  WIDTH  first operand; sampled only with an accepted start.
REQ-006 SHALL have port: b  input  WIDTH  second operand; sampled only with an accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in; sampled only with an accepted start.
REQ-008 SHALL have port: busy  output  1  high while an addition is in progress (state RUN).
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking a completed result.
REQ-010 SHALL have port: sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  registered carry-out of the addition.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL be accepted: latch a, b, cin into internal shift and carry registers, clear the bit counter, and enter RUN.
REQ-014 start=1 while in RUN SHALL be ignored; operands and progress SHALL be unaffected.
REQ-015 In RUN, each edge SHALL process one bit LSB-first through a single full-adder slice: bit = a_i^b_i^c, c <= majority(a_i,b_i,c); the bit shifts into an internal partial-sum register.
REQ-016 After exactly WIDTH RUN edges the FSM SHALL enter DONE, and on that same edge sum and cout SHALL be loaded atomically from the partial-sum and carry registers.
REQ-017 Latency: with start accepted at edge 0, done SHALL be high in the cycle following edge WIDTH and low otherwise.
REQ-018 done SHALL be high for exactly one cycle per accepted start; DONE returns to IDLE on the next edge unless a new start is accepted there.
REQ-019 sum and cout SHALL hold their last loaded value through IDLE and RUN until the next completion; partial results are never visible on sum or cout.
REQ-020 busy SHALL equal (state==RUN); busy and done SHALL never be high together.
REQ-021 All arithmetic SHALL wrap modulo 2^WIDTH, with the overflow bit reported only on cout.

Reset
REQ-022 rst=1 SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter and internal registers, asynchronously and independent of clk.
REQ-023 Reset asserted during RUN SHALL abort the operation with no done pulse; operands already latched SHALL be discarded.
REQ-024 start SHALL be ignored while rst=1; the first accepted start is at the first edge after rst deasserts.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined SHALL add output port ovf (1 bit): the signed two's-complement overflow, (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), loaded together with sum, reset to 0, and held with sum.
REQ-026 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8 unless noted)
REQ-027 a=0x0F, b=0x01, cin=0, start at edge 0 -> busy high for 8 cycles; done pulses after edge 8; sum=0x10, cout=0.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN, a=0x7F, b=0x01 -> sum=0x80, ovf=1, and a=0xFF, b=0x01 -> ovf=0.
REQ-029 Start a=0x12, b=0x34; pulse start with a=0xAA, b=0x55 at RUN cycle 3 -> second start ignored; result sum=0x46, exactly one done.
REQ-030 Assert rst for 1 cycle mid-RUN (cycle 4) -> busy=0, sum=0, cout=0 immediately; no done until a new start completes.
REQ-031 Back-to-back: start held high continuously with new operands each accept -> accepted in DONE cycles; one done per operation, every 9 cycles, all results correct.
REQ-032 WIDTH=1: all 8 combinations of a, b, cin -> sum/cout match the full-adder truth table; done 1 cycle after each start.
